// File: rtl/ysyx_24080006_arbiter.sv
// Two-master to one-slave AXI4 arbiter (fetch read, load/store read+write).
// One whole transaction is granted at a time; channels are forwarded
// combinationally while granted and everything reads as zero in IDLE.

package ysyx_24080006_axi_pkg;

  typedef struct packed {
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        rready;
  } axi_r_m2s_t;

  typedef struct packed {
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;
  } axi_r_s2m_t;

  typedef struct packed {
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        bready;
  } axi_w_m2s_t;

  typedef struct packed {
    logic        awready;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic [3:0]  bid;
  } axi_w_s2m_t;

endpackage

// state  | meaning
// IDLE   | no grant; all outputs 0; arbitrate store > load > fetch
// IFU_R  | fetch read granted until rlast handshake
// LSU_R  | load read granted until rlast handshake
// LSU_W  | store granted until B handshake
module ysyx_24080006_arbiter
  import ysyx_24080006_axi_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  axi_r_m2s_t ifu_r_m2s,
  output axi_r_s2m_t ifu_r_s2m,
  input  axi_r_m2s_t lsu_r_m2s,
  output axi_r_s2m_t lsu_r_s2m,
  input  axi_w_m2s_t lsu_w_m2s,
  output axi_w_s2m_t lsu_w_s2m,
  output axi_r_m2s_t mem_r_m2s,
  input  axi_r_s2m_t mem_r_s2m,
  output axi_w_m2s_t mem_w_m2s,
  input  axi_w_s2m_t mem_w_s2m
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_IFU_R = 2'd1;
  localparam logic [1:0] S_LSU_R = 2'd2;
  localparam logic [1:0] S_LSU_W = 2'd3;

  logic [1:0] state_q;
  logic [1:0] state_d;

  // Next grant: fixed priority from IDLE, hold until the final response handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (lsu_w_m2s.awvalid)      state_d = S_LSU_W;
        else if (lsu_r_m2s.arvalid) state_d = S_LSU_R;
        else if (ifu_r_m2s.arvalid) state_d = S_IFU_R;
      end
      S_IFU_R: begin
        if (mem_r_s2m.rvalid && ifu_r_m2s.rready && mem_r_s2m.rlast) state_d = S_IDLE;
      end
      S_LSU_R: begin
        if (mem_r_s2m.rvalid && lsu_r_m2s.rready && mem_r_s2m.rlast) state_d = S_IDLE;
      end
      S_LSU_W: begin
        if (mem_w_s2m.bvalid && lsu_w_m2s.bready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Grant register; reset abandons any transaction in flight.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Channel steering: only the granted master is connected, everything else reads 0.
  always_comb begin
    ifu_r_s2m = '0;
    lsu_r_s2m = '0;
    lsu_w_s2m = '0;
    mem_r_m2s = '0;
    mem_w_m2s = '0;
    case (state_q)
      S_IFU_R: begin
        mem_r_m2s = ifu_r_m2s;
        ifu_r_s2m = mem_r_s2m;
      end
      S_LSU_R: begin
        mem_r_m2s = lsu_r_m2s;
        lsu_r_s2m = mem_r_s2m;
      end
      S_LSU_W: begin
        mem_w_m2s = lsu_w_m2s;
        lsu_w_s2m = mem_w_s2m;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_24080006_arbiter.sv
// Bench for the two-master AXI arbiter: directed scenarios with literal
// expectations plus a randomized phase checked every cycle against a
// transaction-ownership model.
module tb_ysyx_24080006_arbiter;
  import ysyx_24080006_axi_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  axi_r_m2s_t ifu_r_m2s, lsu_r_m2s, mem_r_m2s;
  axi_r_s2m_t ifu_r_s2m, lsu_r_s2m, mem_r_s2m;
  axi_w_m2s_t lsu_w_m2s, mem_w_m2s;
  axi_w_s2m_t lsu_w_s2m, mem_w_s2m;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  // owner of the downstream port: 0 none, 1 fetch, 2 load, 3 store
  int owner = 0;

  ysyx_24080006_arbiter dut (
    .clock(clock), .reset(reset),
    .ifu_r_m2s(ifu_r_m2s), .ifu_r_s2m(ifu_r_s2m),
    .lsu_r_m2s(lsu_r_m2s), .lsu_r_s2m(lsu_r_s2m),
    .lsu_w_m2s(lsu_w_m2s), .lsu_w_s2m(lsu_w_s2m),
    .mem_r_m2s(mem_r_m2s), .mem_r_s2m(mem_r_s2m),
    .mem_w_m2s(mem_w_m2s), .mem_w_s2m(mem_w_s2m)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ownership model: who holds the port follows from the request/completion rules.
  always @(posedge clock) begin
    if (reset) owner <= 0;
    else if (owner == 0) begin
      if (lsu_w_m2s.awvalid)      owner <= 3;
      else if (lsu_r_m2s.arvalid) owner <= 2;
      else if (ifu_r_m2s.arvalid) owner <= 1;
    end else if (owner == 1) begin
      if (mem_r_s2m.rvalid && ifu_r_m2s.rready && mem_r_s2m.rlast) owner <= 0;
    end else if (owner == 2) begin
      if (mem_r_s2m.rvalid && lsu_r_m2s.rready && mem_r_s2m.rlast) owner <= 0;
    end else begin
      if (mem_w_s2m.bvalid && lsu_w_m2s.bready) owner <= 0;
    end
  end

  // Every-cycle comparison of all five outputs against the owner's expected wiring.
  always @(negedge clock) begin
    if (chk_en) begin
      axi_r_m2s_t e_mem_r;
      axi_w_m2s_t e_mem_w;
      axi_r_s2m_t e_ifu, e_lsu_r;
      axi_w_s2m_t e_lsu_w;
      e_mem_r = '0; e_mem_w = '0; e_ifu = '0; e_lsu_r = '0; e_lsu_w = '0;
      if (owner == 1) begin e_mem_r = ifu_r_m2s; e_ifu = mem_r_s2m; end
      if (owner == 2) begin e_mem_r = lsu_r_m2s; e_lsu_r = mem_r_s2m; end
      if (owner == 3) begin e_mem_w = lsu_w_m2s; e_lsu_w = mem_w_s2m; end
      chk("mem_r_m2s", 128'(mem_r_m2s), 128'(e_mem_r));
      chk("mem_w_m2s", 128'(mem_w_m2s), 128'(e_mem_w));
      chk("ifu_r_s2m", 128'(ifu_r_s2m), 128'(e_ifu));
      chk("lsu_r_s2m", 128'(lsu_r_s2m), 128'(e_lsu_r));
      chk("lsu_w_s2m", 128'(lsu_w_s2m), 128'(e_lsu_w));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_r_m2s = '0; lsu_r_m2s = '0; lsu_w_m2s = '0;
    mem_r_s2m = '0; mem_w_s2m = '0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] r;
    clear_inputs();
    reset = 1'b1;
    tick(); tick();
    #1;
    chk("reset_mem_r", 128'(mem_r_m2s), 128'd0);
    chk("reset_lsu_w", 128'(lsu_w_s2m), 128'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    // IFU-only read
    tick();
    ifu_r_m2s.arvalid = 1'b1; ifu_r_m2s.araddr = 32'h3000_0000; ifu_r_m2s.rready = 1'b1;
    #1 chk("ifu_idle_no_fwd", 128'(mem_r_m2s.arvalid), 128'd0);
    tick();
    mem_r_s2m.arready = 1'b1;
    #1 chk("ifu_araddr", 128'(mem_r_m2s.araddr), 128'h3000_0000);
    chk("ifu_arready", 128'(ifu_r_s2m.arready), 128'd1);
    tick();
    ifu_r_m2s.arvalid = 1'b0; mem_r_s2m.arready = 1'b0;
    mem_r_s2m.rvalid = 1'b1; mem_r_s2m.rdata = 32'hDEAD_BEEF; mem_r_s2m.rlast = 1'b1;
    #1 chk("ifu_rdata", 128'(ifu_r_s2m.rdata), 128'hDEAD_BEEF);
    chk("ifu_lsu_r_zero", 128'(lsu_r_s2m), 128'd0);
    chk("ifu_lsu_w_zero", 128'(lsu_w_s2m), 128'd0);
    tick();
    #1 chk("ifu_back_idle", 128'(ifu_r_s2m.rvalid), 128'd0);
    clear_inputs();

    // Simultaneous fetch and load
    tick();
    ifu_r_m2s.arvalid = 1'b1; ifu_r_m2s.araddr = 32'h100; ifu_r_m2s.rready = 1'b1;
    lsu_r_m2s.arvalid = 1'b1; lsu_r_m2s.araddr = 32'h200; lsu_r_m2s.rready = 1'b1;
    mem_r_s2m.arready = 1'b1;
    tick();
    #1 chk("sim_first_addr", 128'(mem_r_m2s.araddr), 128'h200);
    chk("sim_ifu_arready0", 128'(ifu_r_s2m.arready), 128'd0);
    lsu_r_m2s.arvalid = 1'b0; mem_r_s2m.rvalid = 1'b1; mem_r_s2m.rlast = 1'b1;
    tick();
    #1 chk("sim_gap_idle", 128'(mem_r_m2s.araddr), 128'd0);
    chk("sim_gap_arready0", 128'(ifu_r_s2m.arready), 128'd0);
    mem_r_s2m.rvalid = 1'b0; mem_r_s2m.rlast = 1'b0;
    tick();
    #1 chk("sim_second_addr", 128'(mem_r_m2s.araddr), 128'h100);
    chk("sim_ifu_arready1", 128'(ifu_r_s2m.arready), 128'd1);
    ifu_r_m2s.arvalid = 1'b0; mem_r_s2m.rvalid = 1'b1; mem_r_s2m.rlast = 1'b1;
    tick();
    clear_inputs();

    // Store, W accepted two cycles before AW
    tick();
    lsu_w_m2s.awvalid = 1'b1; lsu_w_m2s.awaddr = 32'h8000_0004;
    lsu_w_m2s.wvalid = 1'b1; lsu_w_m2s.wdata = 32'h0000_AB00; lsu_w_m2s.wstrb = 4'b0010;
    lsu_w_m2s.wlast = 1'b1; lsu_w_m2s.bready = 1'b1;
    tick();
    mem_w_s2m.wready = 1'b1;
    #1 chk("st_wdata", 128'(mem_w_m2s.wdata), 128'h0000_AB00);
    chk("st_wstrb", 128'(mem_w_m2s.wstrb), 128'b0010);
    chk("st_wready", 128'(lsu_w_s2m.wready), 128'd1);
    chk("st_awready0", 128'(lsu_w_s2m.awready), 128'd0);
    tick();
    lsu_w_m2s.wvalid = 1'b0; mem_w_s2m.wready = 1'b0;
    tick();
    mem_w_s2m.awready = 1'b1;
    #1 chk("st_awaddr", 128'(mem_w_m2s.awaddr), 128'h8000_0004);
    chk("st_awready1", 128'(lsu_w_s2m.awready), 128'd1);
    tick();
    lsu_w_m2s.awvalid = 1'b0; mem_w_s2m.awready = 1'b0; mem_w_s2m.bvalid = 1'b1;
    #1 chk("st_bvalid", 128'(lsu_w_s2m.bvalid), 128'd1);
    chk("st_no_read", 128'(mem_r_m2s), 128'd0);
    tick();
    #1 chk("st_idle", 128'(lsu_w_s2m.bvalid), 128'd0);
    clear_inputs();

    // Store vs fetch collision
    tick();
    lsu_w_m2s.awvalid = 1'b1; lsu_w_m2s.bready = 1'b1;
    ifu_r_m2s.arvalid = 1'b1; ifu_r_m2s.araddr = 32'h44; ifu_r_m2s.rready = 1'b1;
    tick();
    #1 chk("col_write_first", 128'(mem_w_m2s.awvalid), 128'd1);
    chk("col_read_held", 128'(mem_r_m2s.arvalid), 128'd0);
    lsu_w_m2s.awvalid = 1'b0; mem_w_s2m.bvalid = 1'b1;
    tick();
    #1 chk("col_gap", 128'(mem_r_m2s.arvalid), 128'd0);
    mem_w_s2m.bvalid = 1'b0;
    tick();
    #1 chk("col_fetch_fwd", 128'(mem_r_m2s.araddr), 128'h44);
    ifu_r_m2s.arvalid = 1'b0; mem_r_s2m.rvalid = 1'b1; mem_r_s2m.rlast = 1'b1;
    tick();
    clear_inputs();

    // Burst hold: 4 beats to IFU, load request arrives during beat 1
    tick();
    ifu_r_m2s.arvalid = 1'b1; ifu_r_m2s.arlen = 8'd3; ifu_r_m2s.araddr = 32'h500;
    ifu_r_m2s.rready = 1'b1;
    tick();
    ifu_r_m2s.arvalid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mem_r_s2m.rvalid = 1'b1; mem_r_s2m.rlast = (b == 3);
      mem_r_s2m.rdata = 32'hA000_0000 + 32'(b);
      if (b == 1) begin
        lsu_r_m2s.arvalid = 1'b1; lsu_r_m2s.araddr = 32'h200; lsu_r_m2s.rready = 1'b1;
      end
      #1 chk("burst_ifu_beat", 128'(ifu_r_s2m.rdata), 128'hA000_0000 + 128'(b));
      chk("burst_lsu_quiet", 128'(lsu_r_s2m.rvalid), 128'd0);
      tick();
    end
    mem_r_s2m.rvalid = 1'b0; mem_r_s2m.rlast = 1'b0;
    #1 chk("burst_gap", 128'(mem_r_m2s.arvalid), 128'd0);
    tick();
    #1 chk("burst_lsu_addr", 128'(mem_r_m2s.araddr), 128'h200);
    tick();
    clear_inputs();
    tick();

    // Reset mid-read with rvalid pending
    lsu_r_m2s.arvalid = 1'b1; lsu_r_m2s.araddr = 32'h600;
    tick();
    lsu_r_m2s.arvalid = 1'b0; mem_r_s2m.rvalid = 1'b1; mem_r_s2m.rlast = 1'b1;
    tick();
    #1 chk("rst_pending", 128'(lsu_r_s2m.rvalid), 128'd1);
    reset = 1'b1;
    tick();
    #1 chk("rst_mem_r", 128'(mem_r_m2s), 128'd0);
    chk("rst_lsu_r", 128'(lsu_r_s2m), 128'd0);
    reset = 1'b0;
    clear_inputs();
    tick();

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      r = rnd128(); ifu_r_m2s = r[$bits(axi_r_m2s_t)-1:0];
      r = rnd128(); lsu_r_m2s = r[$bits(axi_r_m2s_t)-1:0];
      r = rnd128(); lsu_w_m2s = r[$bits(axi_w_m2s_t)-1:0];
      r = rnd128(); mem_r_s2m = r[$bits(axi_r_s2m_t)-1:0];
      r = rnd128(); mem_w_s2m = r[$bits(axi_w_s2m_t)-1:0];
      lsu_w_m2s.awvalid = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 63) == 0);
      tick();
    end
    reset = 1'b0;
    clear_inputs();
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
